// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite OAM DMA engine: halts the CPU and copies page P (256 bytes) to 16'h2004
//
// Ports:
//   clock      system clock (M2 rate), all state changes on the rising edge
//   RST        asynchronous active-low reset
//   cpu_addr   CPU address for the current cycle
//   cpu_wdata  CPU write data for the current cycle
//   cpu_we     CPU write strobe, qualified by cpu_addr
//   cpu_rw     CPU current-cycle direction (1 = read, 0 = write)
//   bus_rdata  shared data bus read value, sampled on the DMA read cycle
//   rdy        CPU ready (0 = halt CPU)
//   dma_busy   DMA owns the address/data bus this cycle
//   dma_addr   DMA bus address
//   dma_wdata  DMA write data
//   dma_we     DMA write strobe
//
// Build option:
//   OAM_DMA_ALIGN_EN  when defined, an odd parity cycle at DUMMY inserts one ALIGN
//                     idle cycle before the first read; when undefined ALIGN is
//                     unreachable and the parity flop does not exist.

module oam_dma (
  input  logic        clock,
  input  logic        RST,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_rdata,
  output logic        rdy,
  output logic        dma_busy,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata,
  output logic        dma_we
);

  localparam logic [15:0] TRIG_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA  = 16'h2004;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_DUMMY,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] data_reg;
  logic       trigger;

  // Only IDLE has rdy=1 and dma_busy=0, so restricting the trigger to IDLE
  // also ignores CPU writes while the CPU is halted or the DMA owns the bus.
  assign trigger = (state == S_IDLE) && cpu_we && (cpu_addr == TRIG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
    end
  end
`endif

  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      idx      <= 8'h00;
      page     <= 8'h00;
      data_reg <= 8'h00;
    end else begin
      state <= state_nxt;
      if (trigger) begin
        page <= cpu_wdata;
      end
      if (state == S_READ) begin
        data_reg <= bus_rdata;
      end
      // idx wraps naturally to 0 after the 256th write
      if (state == S_WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    dma_busy  = 1'b0;
    dma_addr  = 16'h0000;
    dma_wdata = 8'h00;
    dma_we    = 1'b0;
    case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (trigger) begin
          state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        // The CPU only stops on a read cycle; its write cycles keep running.
        if (cpu_rw) begin
          state_nxt = S_DUMMY;
        end
      end
      S_DUMMY: begin
        dma_busy = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
        state_nxt = parity ? S_ALIGN : S_READ;
`else
        state_nxt = S_READ;
`endif
      end
      S_ALIGN: begin
        dma_busy  = 1'b1;
        state_nxt = S_READ;
      end
      S_READ: begin
        dma_busy  = 1'b1;
        dma_addr  = {page, idx};
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        dma_busy  = 1'b1;
        dma_addr  = OAM_DATA;
        dma_wdata = data_reg;
        dma_we    = 1'b1;
        state_nxt = (idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for oam_dma

module tb_oam_dma;

  logic        clock = 1'b0;
  logic        RST;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_rw;
  logic [7:0]  bus_rdata;
  logic        rdy;
  logic        dma_busy;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;

  oam_dma dut (
    .clock     (clock),
    .RST       (RST),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rw    (cpu_rw),
    .bus_rdata (bus_rdata),
    .rdy       (rdy),
    .dma_busy  (dma_busy),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_we    (dma_we)
  );

  always #5 clock = ~clock;

  // Memory contents seen on the shared bus: a fixed function of the address.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign bus_rdata = mem_byte(dma_addr);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: 0 = CPU free, 1 = waiting for a CPU read cycle,
  // 2 = transferring. m_k counts cycles since the CPU was caught on a read.
  int         m_st    = 0;
  int         m_k     = 0;
  bit         m_align = 1'b0;
  bit         m_par   = 1'b0;
  logic [7:0] m_page  = 8'h00;

  always @(posedge clock or negedge RST) begin
    if (!RST) begin
      m_st = 0; m_k = 0; m_align = 1'b0; m_par = 1'b0; m_page = 8'h00;
    end else begin
      case (m_st)
        0: if (cpu_we && cpu_addr == 16'h4014) begin m_st = 1; m_page = cpu_wdata; end
        1: if (cpu_rw) begin m_st = 2; m_k = 0; end
        default: begin
`ifdef OAM_DMA_ALIGN_EN
          if (m_k == 0) m_align = m_par;
`else
          if (m_k == 0) m_align = 1'b0;
`endif
          // 1 dummy + optional align + 512 read/write cycles
          if (m_k == 512 + int'(m_align)) m_st = 0;
          else m_k++;
        end
      endcase
      m_par = !m_par;
    end
  end

  bit         cmp_en = 1'b0;
  logic [7:0] cur_page;
  int         wr_count, rd_count, low_count, off_page;
  logic [7:0] first_wdata, last_wdata;
  logic [15:0] first_rd, last_rd;

  always @(negedge clock) begin
    logic        e_rdy, e_busy, e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    int          j;
    e_rdy  = (m_st == 0);
    e_busy = (m_st == 2);
    e_we   = 1'b0;
    e_addr = 16'h0000;
    e_wd   = 8'h00;
    if (m_st == 2 && m_k > 0 && !(m_align && m_k == 1)) begin
      j = m_k - 1 - int'(m_align);
      if (j % 2 == 0) begin
        e_addr = {m_page, 8'(j / 2)};
      end else begin
        e_addr = 16'h2004;
        e_wd   = mem_byte({m_page, 8'(j / 2)});
        e_we   = 1'b1;
      end
    end
    if (cmp_en) begin
      chk("cyc_rdy", rdy, e_rdy);
      chk("cyc_busy", dma_busy, e_busy);
      chk("cyc_addr", dma_addr, e_addr);
      chk("cyc_wdata", dma_wdata, e_wd);
      chk("cyc_we", dma_we, e_we);
    end
    if (!rdy) low_count++;
    if (dma_we) begin
      if (wr_count == 0) first_wdata = dma_wdata;
      last_wdata = dma_wdata;
      wr_count++;
    end
    if (dma_busy && !dma_we && dma_addr != 16'h0000) begin
      if (rd_count == 0) first_rd = dma_addr;
      last_rd = dma_addr;
      rd_count++;
      if (dma_addr[15:8] != cur_page) off_page++;
    end
  end

  task automatic clr(input logic [7:0] p);
    cur_page = p; wr_count = 0; rd_count = 0; low_count = 0; off_page = 0;
    first_wdata = 8'h00; last_wdata = 8'h00; first_rd = 16'h0000; last_rd = 16'h0000;
  endtask

  task automatic trigger(input logic [7:0] p);
    @(posedge clock); #1;
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = p;
    @(posedge clock); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock); #1;
      if (rdy) return;
    end
    chk("wait_idle_timeout", rdy, 1'b1);
  endtask

  function automatic int exp_low(input int halt_cycles);
`ifdef OAM_DMA_ALIGN_EN
    return halt_cycles + 513 + int'(m_align);
`else
    return halt_cycles + 513;
`endif
  endfunction

  initial begin
    RST = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_rw = 1'b1;
    clr(8'h00);
    repeat (3) @(negedge clock);
    #1;
    chk("reset_rdy", rdy, 1'b1);
    chk("reset_busy", dma_busy, 1'b0);
    chk("reset_addr", dma_addr, 16'h0000);
    chk("reset_wdata", dma_wdata, 8'h00);
    chk("reset_we", dma_we, 1'b0);
    RST = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clock);

    // Basic transfer from page 02 with the CPU already on a read cycle
    clr(8'h02);
    trigger(8'h02);
    @(negedge clock); #1;
    chk("t1_rdy_drop", rdy, 1'b0);
    wait_idle();
    chk("t1_rdy_low", low_count, exp_low(1));
    chk("t1_writes", wr_count, 256);
    chk("t1_reads", rd_count, 256);
    chk("t1_first_rd", first_rd, 16'h0200);
    chk("t1_last_rd", last_rd, 16'h02FF);
    chk("t1_first_wd", first_wdata, 8'hA7);
    chk("t1_last_wd", last_wdata, 8'h58);

    // CPU keeps writing for 3 cycles after the trigger
    clr(8'h02);
    cpu_rw = 1'b0;
    trigger(8'h02);
    repeat (3) begin
      @(negedge clock); #1;
      chk("t2_halt_busy", dma_busy, 1'b0);
      chk("t2_halt_rdy", rdy, 1'b0);
    end
    @(posedge clock); #1;
    cpu_rw = 1'b1;
    @(negedge clock); #1;
    chk("t2_still_halt", dma_busy, 1'b0);
    @(negedge clock); #1;
    chk("t2_dummy_busy", dma_busy, 1'b1);
    chk("t2_dummy_we", dma_we, 1'b0);
    wait_idle();
    chk("t2_rdy_low", low_count, exp_low(4));
    chk("t2_writes", wr_count, 256);

    // Retrigger with page 07 mid-transfer must be ignored
    clr(8'h02);
    trigger(8'h02);
    repeat (50) @(negedge clock);
    @(posedge clock); #1;
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h07;
    @(posedge clock); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    wait_idle();
    chk("t3_off_page", off_page, 0);
    chk("t3_last_rd", last_rd, 16'h02FF);
    chk("t3_last_wd", last_wdata, 8'h58);
    chk("t3_writes", wr_count, 256);
    repeat (4) @(negedge clock);
    #1;
    chk("t3_stays_idle", rdy, 1'b1);

    // Reset at write #100, then a fresh transfer from page 03
    clr(8'h02);
    trigger(8'h02);
    for (int i = 0; i < 1000 && wr_count < 100; i++) begin
      @(negedge clock); #1;
    end
    chk("t4_reached_100", wr_count, 100);
    RST = 1'b0;
    #1;
    chk("t4_abort_we", dma_we, 1'b0);
    chk("t4_abort_rdy", rdy, 1'b1);
    chk("t4_abort_busy", dma_busy, 1'b0);
    chk("t4_abort_addr", dma_addr, 16'h0000);
    repeat (2) @(negedge clock);
    #1;
    RST = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    chk("t4_no_more_writes", wr_count, 100);
    clr(8'h03);
    trigger(8'h03);
    wait_idle();
    chk("t4_writes", wr_count, 256);
    chk("t4_first_rd", first_rd, 16'h0300);
    chk("t4_first_wd", first_wdata, 8'hA6);
    chk("t4_last_rd", last_rd, 16'h03FF);

    // Page FF: reads FF00..FFFF, idx wraps, back to idle
    clr(8'hFF);
    trigger(8'hFF);
    wait_idle();
    chk("t5_writes", wr_count, 256);
    chk("t5_first_rd", first_rd, 16'hFF00);
    chk("t5_last_rd", last_rd, 16'hFFFF);
    chk("t5_last_wd", last_wdata, 8'hA5);
    chk("t5_off_page", off_page, 0);
    chk("t5_idle", rdy, 1'b1);

    // idx must have wrapped: the next transfer starts at offset 00
    clr(8'h01);
    trigger(8'h01);
    wait_idle();
    chk("t6_first_rd", first_rd, 16'h0100);
    chk("t6_writes", wr_count, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
